// File: rtl/layer_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// layer_scheduler_pkg
// Shared types and helpers for the layer scheduler and its statistics block.
//   sched_state_t : scheduler FSM state encoding
//   sat_inc       : saturating increment on a SAT_W-bit value against a ceiling
// Optional feature macro used by the design: LAYER_SCHEDULER_STATS_EN
// -----------------------------------------------------------------------------
package layer_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_START,
        ST_RUN,
        ST_CACHE
    } sched_state_t;

    localparam int SAT_W = 32;

    // Callers zero-extend their counter and its all-ones ceiling to SAT_W bits
    // and truncate the result back, so one function serves any width <= 32.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                 input logic [SAT_W-1:0] max_value);
        if (value >= max_value) begin
            return max_value;
        end
        return value + 32'd1;
    endfunction

endpackage

// File: rtl/layer_scheduler_stats.sv
// -----------------------------------------------------------------------------
// layer_scheduler_stats
// Frame-length statistics for the layer scheduler. Counts cycles while a frame
// is active (saturating); on frame completion publishes the length including
// the completing cycle and tracks the maximum. Aborted frames publish nothing.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   frame_active        : scheduler is busy (SHIFT through final CACHE)
//   frame_done          : current cycle is the final CACHE of a frame
//   frame_abort         : current cycle is a layer timeout
//   last_frame_cycles   : length of the last completed frame
//   max_frame_cycles    : longest completed frame since reset
// -----------------------------------------------------------------------------
module layer_scheduler_stats
    import layer_scheduler_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_active,
    input  logic             frame_done,
    input  logic             frame_abort,
    output logic [CNT_W-1:0] last_frame_cycles,
    output logic [CNT_W-1:0] max_frame_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] count_inc;

    // count_q holds the cycles already spent in the frame, so count_inc is the
    // length including the current cycle; that is the value published on done.
    always_comb begin
        count_inc = CNT_W'(sat_inc(SAT_W'(count_q), SAT_W'(CNT_MAX)));
        count_d   = count_q;
        last_d    = last_q;
        max_d     = max_q;
        if (!frame_active || frame_abort) begin
            count_d = '0;
        end else begin
            count_d = count_inc;
        end
        if (frame_done) begin
            last_d = count_inc;
            if (count_inc > max_q) begin
                max_d = count_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            last_q  <= '0;
            max_q   <= '0;
        end else begin
            count_q <= count_d;
            last_q  <= last_d;
            max_q   <= max_d;
        end
    end

    assign last_frame_cycles = last_q;
    assign max_frame_cycles  = max_q;

endmodule

// File: rtl/layer_scheduler.sv
// -----------------------------------------------------------------------------
// layer_scheduler
// Frame sequencer for the dilated-conv pipeline. Each rising edge of
// sample_clk steps the input shift buffer, then each conv layer is started,
// awaited and its output cached in turn. Edges arriving mid-frame are counted
// as overruns; a layer that never signals done within TIMEOUT cycles aborts
// the frame and sets a sticky error.
// Optional feature: define LAYER_SCHEDULER_STATS_EN for frame-length stats;
// otherwise last_frame_cycles / max_frame_cycles are tied to zero.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   sample_clk         : sample clock, already synchronised to clk
//   shift_stb          : one-cycle pulse clocking the input shift buffer
//   layer_start[i]     : one-cycle pulse starting layer i
//   layer_done[i]      : layer i output valid (level)
//   cache_stb[i]       : one-cycle pulse capturing layer i output
//   busy               : scheduler not idle
//   overrun_cnt        : saturating count of edges seen while busy
//   timeout_err        : sticky layer-timeout flag
//   last_frame_cycles  : cycles of the last completed frame
//   max_frame_cycles   : maximum over completed frames
// -----------------------------------------------------------------------------
module layer_scheduler
    import layer_scheduler_pkg::*;
#(
    parameter int N_LAYERS = 3,
    parameter int TIMEOUT  = 4096,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_clk,
    output logic                shift_stb,
    output logic [N_LAYERS-1:0] layer_start,
    input  logic [N_LAYERS-1:0] layer_done,
    output logic [N_LAYERS-1:0] cache_stb,
    output logic                busy,
    output logic [CNT_W-1:0]    overrun_cnt,
    output logic                timeout_err,
    output logic [CNT_W-1:0]    last_frame_cycles,
    output logic [CNT_W-1:0]    max_frame_cycles
);

    localparam int LI_W   = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [LI_W-1:0]   LAST_LI   = LI_W'(N_LAYERS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    sched_state_t      state_q, state_d;
    logic [LI_W-1:0]   li_q, li_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              prev_sample_q, prev_sample_d;
    logic [CNT_W-1:0]  overrun_q, overrun_d;
    logic              timeout_q, timeout_d;

    logic sample_edge;
    logic done_sel;
    logic wait_expired;

    assign sample_edge  = sample_clk & ~prev_sample_q;
    assign done_sel     = layer_done[li_q];
    assign wait_expired = (wait_q == WAIT_LAST);

    // Next-state logic plus Moore strobe decode. Overruns are counted in every
    // non-idle state, including the final CACHE cycle, and never disturb the
    // frame in progress. In RUN, done is tested before the timeout so a layer
    // finishing on the last allowed cycle still completes.
    always_comb begin
        state_d       = state_q;
        li_d          = li_q;
        wait_d        = wait_q;
        timeout_d     = timeout_q;
        prev_sample_d = sample_clk;
        overrun_d     = overrun_q;

        shift_stb   = 1'b0;
        layer_start = '0;
        cache_stb   = '0;
        busy        = (state_q != ST_IDLE);

        if (sample_edge && (state_q != ST_IDLE)) begin
            overrun_d = CNT_W'(sat_inc(SAT_W'(overrun_q), SAT_W'(CNT_MAX)));
        end

        case (state_q)
            ST_IDLE: begin
                if (sample_edge) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_stb = 1'b1;
                li_d      = '0;
                state_d   = ST_START;
            end
            ST_START: begin
                layer_start[li_q] = 1'b1;
                wait_d            = '0;
                state_d           = ST_RUN;
            end
            ST_RUN: begin
                if (done_sel) begin
                    state_d = ST_CACHE;
                end else if (wait_expired) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_CACHE: begin
                cache_stb[li_q] = 1'b1;
                if (li_q == LAST_LI) begin
                    state_d = ST_IDLE;
                end else begin
                    li_d    = li_q + LI_W'(1);
                    state_d = ST_START;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            li_q          <= '0;
            wait_q        <= '0;
            prev_sample_q <= 1'b0;
            overrun_q     <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            li_q          <= li_d;
            wait_q        <= wait_d;
            prev_sample_q <= prev_sample_d;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
        end
    end

    assign overrun_cnt = overrun_q;
    assign timeout_err = timeout_q;

`ifdef LAYER_SCHEDULER_STATS_EN
    logic frame_active;
    logic frame_done;
    logic frame_abort;

    assign frame_active = (state_q != ST_IDLE);
    assign frame_done   = (state_q == ST_CACHE) && (li_q == LAST_LI);
    assign frame_abort  = (state_q == ST_RUN) && !done_sel && wait_expired;

    layer_scheduler_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk               (clk),
        .rst               (rst),
        .frame_active      (frame_active),
        .frame_done        (frame_done),
        .frame_abort       (frame_abort),
        .last_frame_cycles (last_frame_cycles),
        .max_frame_cycles  (max_frame_cycles)
    );
`else
    assign last_frame_cycles = '0;
    assign max_frame_cycles  = '0;
`endif

endmodule
